// File: rtl/rv_dmem_mmio_if.sv
// Core data-memory bus plus trace drain handshake between the core/bench and rv_dmem_mmio.
interface rv_dmem_mmio_if #(
  parameter int DPWIDTH = 32
);
  logic [DPWIDTH-1:0] dmem_addr;
  logic [DPWIDTH-1:0] dmem_dataout;
  logic               memrw;
  logic [DPWIDTH-1:0] dmem_datain;
  logic               trace_valid;
  logic               trace_ready;
  logic [DPWIDTH-1:0] trace_addr;
  logic [DPWIDTH-1:0] trace_data;

  modport master (
    output dmem_addr, dmem_dataout, memrw, trace_ready,
    input  dmem_datain, trace_valid, trace_addr, trace_data
  );

  modport slave (
    input  dmem_addr, dmem_dataout, memrw, trace_ready,
    output dmem_datain, trace_valid, trace_addr, trace_data
  );
endinterface

// File: rtl/rv_dmem_mmio.sv
// Data-memory bridge: decodes core accesses to RAM or MMIO (done, cycle count, store count)
// and queues every accepted RAM store in a show-ahead trace FIFO.
module rv_dmem_mmio #(
  parameter int                 DPWIDTH      = 32,
  parameter int                 LOGDMEM_SIZE = 10,
  parameter logic [DPWIDTH-1:0] DONE_ADDR    = 32'h0000FFFF,
  parameter logic [DPWIDTH-1:0] DONE_DATA    = 32'h0000DEAD,
  parameter logic [DPWIDTH-1:0] CYCLE_ADDR   = 32'h0000FFF0,
  parameter logic [DPWIDTH-1:0] STCNT_ADDR   = 32'h0000FFF4,
  parameter int                 LOG_DEPTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  rv_dmem_mmio_if.slave           io_bus,
  output logic [LOGDMEM_SIZE-1:0] o_ram_addr,
  output logic [DPWIDTH-1:0]      o_ram_wdata,
  output logic                    o_ram_we,
  input  logic [DPWIDTH-1:0]      i_ram_rdata,
  output logic                    o_done,
  output logic                    o_misalign,
  output logic                    o_trace_overflow
);

  localparam int                 DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic                 r_done;
  logic                 r_misalign;
  logic                 r_overflow;
  logic [DPWIDTH-1:0]   r_cycle_cnt;
  logic [DPWIDTH-1:0]   r_store_cnt;
  logic [LOG_DEPTH-1:0] r_wptr;
  logic [LOG_DEPTH-1:0] r_rptr;
  logic [LOG_DEPTH:0]   r_count;
  logic [DPWIDTH-1:0]   r_fifo_addr [DEPTH];
  logic [DPWIDTH-1:0]   r_fifo_data [DEPTH];

  logic w_sel_done, w_sel_cycle, w_sel_stcnt, w_is_ram;
  logic w_accept, w_ram_we, w_set_done, w_misaligned;
  logic w_full, w_valid, w_pop, w_do_push, w_drop;

  // Address decode: only the three exact MMIO addresses leave the RAM region.
  assign w_sel_done  = (io_bus.dmem_addr == DONE_ADDR);
  assign w_sel_cycle = (io_bus.dmem_addr == CYCLE_ADDR);
  assign w_sel_stcnt = (io_bus.dmem_addr == STCNT_ADDR);
  assign w_is_ram    = ~(w_sel_done | w_sel_cycle | w_sel_stcnt);

  assign w_accept     = io_bus.memrw & ~r_done;
  assign w_ram_we     = w_accept & w_is_ram;
  assign w_set_done   = w_accept & w_sel_done & (io_bus.dmem_dataout == DONE_DATA);
  assign w_misaligned = (io_bus.memrw | w_is_ram) & (|io_bus.dmem_addr[1:0]);

  assign o_ram_addr  = io_bus.dmem_addr[LOGDMEM_SIZE+1:2];
  assign o_ram_wdata = io_bus.dmem_dataout;
  assign o_ram_we    = w_ram_we;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    io_bus.dmem_datain = i_ram_rdata;
    if (w_sel_cycle)      io_bus.dmem_datain = r_cycle_cnt;
    else if (w_sel_stcnt) io_bus.dmem_datain = r_store_cnt;
    else if (w_sel_done)  io_bus.dmem_datain = {{(DPWIDTH-1){1'b0}}, r_done};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
    end else begin
      if (w_set_done) r_done <= 1'b1;
      if (w_misaligned) r_misalign <= 1'b1;
      if (!r_done) r_cycle_cnt <= r_cycle_cnt + DPWIDTH'(1);
      if (w_ram_we) r_store_cnt <= r_store_cnt + DPWIDTH'(1);
    end
  end

  // Trace FIFO: a push into a full FIFO is kept only when the head pops in the same cycle.
  assign w_full    = (r_count == FULL_CNT);
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & io_bus.trace_ready;
  assign w_do_push = w_ram_we & (~w_full | w_pop);
  assign w_drop    = w_ram_we & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + LOG_DEPTH'(1);
      if (w_pop)     r_rptr <= r_rptr + LOG_DEPTH'(1);
      if (w_drop)    r_overflow <= 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + (LOG_DEPTH + 1)'(1);
        2'b01:   r_count <= r_count - (LOG_DEPTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_fifo_addr[r_wptr] <= io_bus.dmem_addr;
      r_fifo_data[r_wptr] <= io_bus.dmem_dataout;
    end
  end

  assign io_bus.trace_valid = w_valid;
  assign io_bus.trace_addr  = r_fifo_addr[r_rptr];
  assign io_bus.trace_data  = r_fifo_data[r_rptr];

  assign o_done           = r_done;
  assign o_misalign       = r_misalign;
  assign o_trace_overflow = r_overflow;

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// Randomised self-checking bench for rv_dmem_mmio against a queue-based transaction model.
module tb_rv_dmem_mmio;

  localparam logic [31:0] DONE_ADDR  = 32'h0000FFFF;
  localparam logic [31:0] DONE_DATA  = 32'h0000DEAD;
  localparam logic [31:0] CYCLE_ADDR = 32'h0000FFF0;
  localparam logic [31:0] STCNT_ADDR = 32'h0000FFF4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, done, misalign, trace_overflow;

  rv_dmem_mmio_if #(.DPWIDTH(32)) bus ();

  rv_dmem_mmio dut (
    .clk(clk), .rst(rst), .io_bus(bus),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
    .i_ram_rdata(ram_rdata), .o_done(done), .o_misalign(misalign),
    .o_trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  // Backing RAM with asynchronous read, as the core's data RAM would be.
  logic [31:0] ram [1024];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  // Reference model state
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [31:0] m_cyc, m_stc;
  logic        m_done, m_mis, m_ovf;
  logic [31:0] ref_mem [1024];
  bit          ref_ok  [1024];

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] obs_datain;
  logic        obs_we, obs_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_data.delete();
    m_cyc = '0; m_stc = '0;
    m_done = 1'b0; m_mis = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bus.dmem_addr = '0; bus.dmem_dataout = '0; bus.memrw = 1'b0; bus.trace_ready = 1'b0;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One bus cycle: drive, compare combinational and registered outputs, then advance the model.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
    logic        is_mmio, exp_we, full, pop;
    logic [9:0]  idx;
    logic [31:0] exp_rd;
    bus.dmem_addr = a; bus.dmem_dataout = d; bus.memrw = we; bus.trace_ready = rdy;
    #2;
    is_mmio = (a == DONE_ADDR) || (a == CYCLE_ADDR) || (a == STCNT_ADDR);
    idx     = a[11:2];
    exp_we  = we && !m_done && !is_mmio;
    obs_datain = bus.dmem_datain;
    obs_we     = ram_we;
    obs_valid  = bus.trace_valid;

    check("done", {31'b0, done}, {31'b0, m_done});
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    check("overflow", {31'b0, trace_overflow}, {31'b0, m_ovf});
    check("ram_we", {31'b0, ram_we}, {31'b0, exp_we});
    if (exp_we) begin
      check("ram_addr", {22'b0, ram_addr}, {22'b0, idx});
      check("ram_wdata", ram_wdata, d);
    end
    if (a == CYCLE_ADDR)      exp_rd = m_cyc;
    else if (a == STCNT_ADDR) exp_rd = m_stc;
    else if (a == DONE_ADDR)  exp_rd = {31'b0, m_done};
    else                      exp_rd = ref_mem[idx];
    if (is_mmio || ref_ok[idx]) check("datain", obs_datain, exp_rd);
    check("trace_valid", {31'b0, bus.trace_valid}, {31'b0, q_addr.size() != 0});
    if (q_addr.size() != 0) begin
      check("trace_addr", bus.trace_addr, q_addr[0]);
      check("trace_data", bus.trace_data, q_data[0]);
    end

    full = (q_addr.size() == 8);
    pop  = (q_addr.size() != 0) && rdy;
    if (pop) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (exp_we) begin
      ref_mem[idx] = d;
      ref_ok[idx]  = 1'b1;
      m_stc = m_stc + 32'd1;
      if (!full || pop) begin
        q_addr.push_back(a);
        q_data.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if ((we || !is_mmio) && (a[1:0] != 2'b00)) m_mis = 1'b1;
    if (!m_done) m_cyc = m_cyc + 32'd1;
    if (we && !m_done && (a == DONE_ADDR) && (d == DONE_DATA)) m_done = 1'b1;

    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int exp_n);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(32'h0, 32'h0, 1'b0, 1'b1);
      if (obs_valid) n++;
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    int r;
    logic [31:0] a, d;
    for (int i = 0; i < 1024; i++) ref_ok[i] = 1'b0;
    model_reset();

    // Reset, then the cycle counter reads back the number of elapsed cycles.
    do_reset(3);
    repeat (10) cyc(32'h0, 32'h0, 1'b0, 1'b0);
    cyc(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
    check("t1_cycle10", obs_datain, 32'd10);

    // Single store lands in RAM and in the trace FIFO the following cycle.
    cyc(32'h40, 32'h1234, 1'b1, 1'b0);
    check("t2_we", {31'b0, obs_we}, 32'd1);
    cyc(STCNT_ADDR, 32'h0, 1'b0, 1'b0);
    check("t2_stcnt", obs_datain, 32'd1);
    check("t2_valid", {31'b0, obs_valid}, 32'd1);
    drain("t2_drain", 1);

    // Nine stores with no drain: eight kept, one dropped.
    for (int i = 0; i < 9; i++) cyc(32'h100 + 32'(i * 4), $urandom, 1'b1, 1'b0);
    check("t3_overflow", {31'b0, trace_overflow}, 32'd1);
    drain("t3_drain", 8);

    // Full FIFO with a simultaneous pop keeps the new store.
    do_reset(1);
    for (int i = 0; i < 8; i++) cyc(32'h200 + 32'(i * 4), $urandom, 1'b1, 1'b0);
    cyc(32'h220, 32'hCAFE0001, 1'b1, 1'b1);
    check("t4_overflow", {31'b0, trace_overflow}, 32'd0);
    drain("t4_drain", 8);

    // Completion register: wrong data ignored, DONE_DATA sets done and freezes everything.
    cyc(DONE_ADDR, 32'hBEEF, 1'b1, 1'b0);
    check("t5_not_done", {31'b0, done}, 32'd0);
    cyc(DONE_ADDR, DONE_DATA, 1'b1, 1'b0);
    check("t5_done", {31'b0, done}, 32'd1);
    cyc(32'h40, 32'h5555, 1'b1, 1'b0);
    check("t5_we_blocked", {31'b0, obs_we}, 32'd0);
    repeat (3) cyc(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);

    // Misaligned load reads the aligned-down word; RAM survives reset.
    do_reset(1);
    cyc(32'h42, 32'h0, 1'b0, 1'b0);
    check("t6_data", obs_datain, 32'h1234);
    check("t6_misalign", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(32'h300 + 32'(i * 4), $urandom, 1'b1, 1'b0);
    do_reset(1);
    cyc(CYCLE_ADDR, 32'h0, 1'b0, 1'b0);
    check("t6_cycle0", obs_datain, 32'd0);
    check("t6_valid0", {31'b0, obs_valid}, 32'd0);

    // Random traffic in several segments, each starting from reset.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(1 + seg);
      for (int i = 0; i < 600; i++) begin
        r = $urandom_range(0, 99);
        d = $urandom;
        if (r < 3) begin
          a = DONE_ADDR;
          if ($urandom_range(0, 3) == 0) d = DONE_DATA;
        end
        else if (r < 7)  a = CYCLE_ADDR;
        else if (r < 11) a = STCNT_ADDR;
        else if (r < 15) a = 32'($urandom_range(0, 8191));
        else             a = 32'($urandom_range(0, 2047)) << 2;
        cyc(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
